pwm_multicanal: RTL

//  Parametrised multi-channel PWM generator, successor to the single 10-bit duty/counter comparator.

---
 rtl/pwm_multicanal_if.sv | 24 ++
 rtl/pwm_multicanal.sv | 112 +++++++++++
 2 files changed

// File: rtl/pwm_multicanal_if.sv
// Control/output bundle for pwm_multicanal: configuration strobes in, PWM lines out.
// The master drives the configuration; the slave (the PWM block) drives the outputs.
interface pwm_multicanal_if #(
    parameter int WIDTH    = 10,
    parameter int CHANNELS = 4
);
    logic                      en;
    logic                      load;
    logic [WIDTH-1:0]          period;
    logic [CHANNELS*WIDTH-1:0] duty;
    logic                      center_mode;
    logic [CHANNELS-1:0]       pwm;
    logic                      period_end;

    modport master (
        output en, load, period, duty, center_mode,
        input  pwm, period_end
    );

    modport slave (
        input  en, load, period, duty, center_mode,
        output pwm, period_end
    );
endinterface

// File: rtl/pwm_multicanal.sv
// Multi-channel edge/center-aligned PWM with double-buffered config; pwm/period_end lag cnt by one cycle.
// No backpressure: load is a strobe that is always accepted; a later load overwrites the pending set.
module pwm_multicanal #(
    parameter int WIDTH    = 10,
    parameter int CHANNELS = 4
) (
    input  logic             clk,
    input  logic             reset,
    pwm_multicanal_if.slave  bus
);

    logic [WIDTH-1:0]          cnt_q, cnt_d;
    logic                      dir_q, dir_d;          // 1 = counting down (center mode only)
    logic                      pend_vld_q, pend_vld_d;
    logic [WIDTH-1:0]          pend_p_q, pend_p_d;
    logic [CHANNELS*WIDTH-1:0] pend_d_q, pend_d_d;
    logic                      pend_mode_q, pend_mode_d;
    logic [WIDTH-1:0]          act_p_q, act_p_d;
    logic [CHANNELS*WIDTH-1:0] act_d_q, act_d_d;
    logic                      act_mode_q, act_mode_d;
    logic [CHANNELS-1:0]       pwm_q, pwm_d;
    logic                      period_end_q, period_end_d;

    logic [WIDTH-1:0]          cnt_nxt;
    logic                      dir_nxt;
    logic                      bnd;
    logic                      xfer;

    // Free-running counter step; bnd marks the last cycle of a period (next cnt=0, dir=up).
    always_comb begin
        cnt_nxt = cnt_q;
        dir_nxt = dir_q;
        bnd     = 1'b0;
        if (act_p_q == '0) begin
            cnt_nxt = '0;
            dir_nxt = 1'b0;
            bnd     = 1'b1;
        end else if (!act_mode_q) begin
            bnd     = (cnt_q >= act_p_q);
            cnt_nxt = bnd ? '0 : cnt_q + WIDTH'(1);
            dir_nxt = 1'b0;
        end else if (!dir_q) begin
            if (cnt_q >= act_p_q) begin
                cnt_nxt = cnt_q - WIDTH'(1);
                bnd     = (cnt_q == WIDTH'(1));
                dir_nxt = !bnd;
            end else begin
                cnt_nxt = cnt_q + WIDTH'(1);
            end
        end else begin
            bnd     = (cnt_q <= WIDTH'(1));
            cnt_nxt = bnd ? '0 : cnt_q - WIDTH'(1);
            dir_nxt = !bnd;
        end
    end

    always_comb begin
        cnt_d        = bus.en ? cnt_nxt : '0;
        dir_d        = bus.en ? dir_nxt : 1'b0;
        xfer         = pend_vld_q & (~bus.en | bnd);
        pend_vld_d   = pend_vld_q & ~xfer;
        pend_p_d     = pend_p_q;
        pend_d_d     = pend_d_q;
        pend_mode_d  = pend_mode_q;
        act_p_d      = xfer ? pend_p_q    : act_p_q;
        act_d_d      = xfer ? pend_d_q    : act_d_q;
        act_mode_d   = xfer ? pend_mode_q : act_mode_q;
        // A load in the transfer cycle lands in pending after the old pending has moved out.
        if (bus.load) begin
            pend_vld_d  = 1'b1;
            pend_p_d    = bus.period;
            pend_d_d    = bus.duty;
            pend_mode_d = bus.center_mode;
        end
        for (int i = 0; i < CHANNELS; i++) begin
            pwm_d[i] = bus.en & (act_d_q[i*WIDTH +: WIDTH] > cnt_q);
        end
        period_end_d = bus.en & bnd;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q        <= '0;
            dir_q        <= 1'b0;
            pend_vld_q   <= 1'b0;
            pend_p_q     <= '0;
            pend_d_q     <= '0;
            pend_mode_q  <= 1'b0;
            act_p_q      <= '1;
            act_d_q      <= '0;
            act_mode_q   <= 1'b0;
            pwm_q        <= '0;
            period_end_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            dir_q        <= dir_d;
            pend_vld_q   <= pend_vld_d;
            pend_p_q     <= pend_p_d;
            pend_d_q     <= pend_d_d;
            pend_mode_q  <= pend_mode_d;
            act_p_q      <= act_p_d;
            act_d_q      <= act_d_d;
            act_mode_q   <= act_mode_d;
            pwm_q        <= pwm_d;
            period_end_q <= period_end_d;
        end
    end

    assign bus.pwm        = pwm_q;
    assign bus.period_end = period_end_q;

endmodule
